// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// run-state encoding, default counter width and the NOP encoding used on flush/bubble.
package pipeline_control_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam int NB_COUNTER_DEF = 32;

   // Instruction word and ID/EX control word loaded when a stage is flushed or bubbled.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [15:0] NOP_CTRL  = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_count <= '0;
      else if (i_inc && (r_count != {WIDTH{1'b1}}))
         r_count <= r_count + WIDTH'(1);
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush controller: decodes hazard requests into stage enables and
// runs the debug IDLE/RUN/STEP/HALTED machine with saturating cycle/stall counters.
module pipeline_control
   import pipeline_control_pkg::*;
#(
   parameter int NB_COUNTER = NB_COUNTER_DEF
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_load_use_stall,
   input  logic                  i_branch_taken,
   input  logic                  i_mem_busy,
   input  logic                  i_wb_halt,
   input  logic                  i_dbg_run,
   input  logic                  i_dbg_step,
   output logic                  o_pc_enable,
   output logic                  o_ifid_enable,
   output logic                  o_ifid_flush,
   output logic                  o_idex_enable,
   output logic                  o_idex_bubble,
   output logic                  o_exmem_enable,
   output logic                  o_memwb_enable,
   output logic                  o_halted,
   output logic                  o_step_done,
   output logic [NB_COUNTER-1:0] o_cycle_count,
   output logic [NB_COUNTER-1:0] o_stall_count
);

   state_t                r_state;
   logic                  r_step_done;
   logic                  w_active;
   logic                  w_stall_inc;
   logic [NB_COUNTER-1:0] w_cycle_count;
   logic [NB_COUNTER-1:0] w_stall_count;

   assign w_active    = (r_state == ST_RUN) || (r_state == ST_STEP);
   assign w_stall_inc = w_active && (i_mem_busy || i_load_use_stall);

   // Zero-latency decode so a hazard detected in decode stalls on this same edge.
   always_comb begin
      o_pc_enable    = 1'b0;
      o_ifid_enable  = 1'b0;
      o_ifid_flush   = 1'b0;
      o_idex_enable  = 1'b0;
      o_idex_bubble  = 1'b0;
      o_exmem_enable = 1'b0;
      o_memwb_enable = 1'b0;
      if (!i_reset && w_active && !i_mem_busy) begin
         o_idex_enable  = 1'b1;
         o_exmem_enable = 1'b1;
         o_memwb_enable = 1'b1;
         if (i_load_use_stall) begin
            // Branch is re-evaluated in decode after the stall, so no flush here.
            o_idex_bubble = 1'b1;
         end else begin
            o_pc_enable   = 1'b1;
            o_ifid_enable = 1'b1;
            o_ifid_flush  = i_branch_taken;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_step_done <= 1'b0;
      end else begin
         r_step_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_dbg_run)
                  r_state <= ST_RUN;
               else if (i_dbg_step)
                  r_state <= ST_STEP;
            end
            ST_RUN: begin
               if (!i_mem_busy && i_wb_halt)
                  r_state <= ST_HALTED;
            end
            ST_STEP: begin
               if (!i_mem_busy) begin
                  r_step_done <= 1'b1;
                  r_state     <= i_wb_halt ? ST_HALTED : ST_IDLE;
               end
            end
            default: r_state <= ST_HALTED;
         endcase
      end
   end

   sat_counter #(.WIDTH(NB_COUNTER)) u_cycle_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_inc   (w_active),
      .o_count (w_cycle_count)
   );

   sat_counter #(.WIDTH(NB_COUNTER)) u_stall_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_inc   (w_stall_inc),
      .o_count (w_stall_count)
   );

   // Registered outputs are also masked so everything reads 0 while reset is held.
   assign o_halted      = !i_reset && (r_state == ST_HALTED);
   assign o_step_done   = !i_reset && r_step_done;
   assign o_cycle_count = i_reset ? '0 : w_cycle_count;
   assign o_stall_count = i_reset ? '0 : w_stall_count;

endmodule
